gcd_iter_unit: RTL and testbench

//   Parametrised multi-cycle GCD engine, successor to the fixed 16-bit mod_d

---
 rtl/gcd_iter_unit_pkg.sv | 18 +
 rtl/gcd_iter_unit_step.sv | 57 +++++
 rtl/gcd_iter_unit.sv | 105 ++++++++++
 tb/tb_gcd_iter_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gcd_iter_unit_pkg.sv
// Shared types and helpers for the iterative GCD engine.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } gcd_state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;

    // K counts common factors of two, so it must reach WIDTH.
    function automatic int unsigned k_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/gcd_iter_unit_step.sv
// One combinational GCD iteration: termination test, then a subtractive or Stein step.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned KW    = k_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [KW-1:0]    i_k,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_a_nxt,
    output logic [WIDTH-1:0] o_b_nxt,
    output logic [KW-1:0]    o_k_nxt,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    logic [WIDTH-1:0] w_diff_ab;
    logic [WIDTH-1:0] w_diff_ba;

    assign w_diff_ab = i_a - i_b;
    assign w_diff_ba = i_b - i_a;

    always_comb begin
        o_a_nxt  = i_a;
        o_b_nxt  = i_b;
        o_k_nxt  = i_k;
        o_done   = 1'b0;
        o_result = '0;
        if (i_a == '0) begin
            o_done   = 1'b1;
            o_result = i_b << i_k;
        end else if ((i_b == '0) || (i_a == i_b)) begin
            o_done   = 1'b1;
            o_result = i_a << i_k;
        end else if (i_mode == MODE_SUB) begin
            if (i_a > i_b) o_a_nxt = w_diff_ab;
            else           o_b_nxt = w_diff_ba;
        end else begin
            if (!i_a[0] && !i_b[0]) begin
                o_a_nxt = i_a >> 1;
                o_b_nxt = i_b >> 1;
                o_k_nxt = i_k + KW'(1);
            end else if (!i_a[0]) begin
                o_a_nxt = i_a >> 1;
            end else if (!i_b[0]) begin
                o_b_nxt = i_b >> 1;
            end else if (i_a > i_b) begin
                o_a_nxt = w_diff_ab >> 1;
            end else begin
                o_b_nxt = w_diff_ba >> 1;
            end
        end
    end

endmodule

// File: rtl/gcd_iter_unit.sv
// Multi-cycle GCD engine with START/READY handshake, selectable Euclid/Stein
// iteration and a saturating count of CALC cycles.
module gcd_iter_unit
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             MODE,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] OUT,
    output logic             READY,
    output logic             BUSY,
    output logic [CNT_W-1:0] CYCLES
);

    localparam int unsigned KW = k_width(WIDTH);

    gcd_state_t       r_state;
    gcd_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [KW-1:0]    r_k;
    logic             r_mode;
    logic [WIDTH-1:0] r_out;
    logic [CNT_W-1:0] r_cycles;

    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [KW-1:0]    w_k_nxt;
    logic             w_done;
    logic [WIDTH-1:0] w_result;
    logic             w_load;

    gcd_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_k      (r_k),
        .i_mode   (r_mode),
        .o_a_nxt  (w_a_nxt),
        .o_b_nxt  (w_b_nxt),
        .o_k_nxt  (w_k_nxt),
        .o_done   (w_done),
        .o_result (w_result)
    );

    assign w_load = START && (r_state != ST_CALC);

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (START)  w_state_nxt = ST_CALC;
            ST_CALC: if (w_done) w_state_nxt = ST_DONE;
            ST_DONE: if (START)  w_state_nxt = ST_CALC;
            default:             w_state_nxt = ST_IDLE;
        endcase
    end

    // READY/BUSY are pure state decodes; they match the registered flags exactly.
    always_comb begin
        READY  = (r_state == ST_DONE);
        BUSY   = (r_state == ST_CALC);
        OUT    = r_out;
        CYCLES = r_cycles;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_a      <= '0;
            r_b      <= '0;
            r_k      <= '0;
            r_mode   <= MODE_SUB;
            r_out    <= '0;
            r_cycles <= '0;
        end else if (w_load) begin
            r_a      <= X;
            r_b      <= Y;
            r_k      <= '0;
            r_mode   <= MODE;
            r_cycles <= '0;
        end else if (r_state == ST_CALC) begin
            if (r_cycles != '1) r_cycles <= r_cycles + CNT_W'(1);
            if (w_done) begin
                r_out <= w_result;
            end else begin
                r_a <= w_a_nxt;
                r_b <= w_b_nxt;
                r_k <= w_k_nxt;
            end
        end
    end

endmodule

// File: tb/tb_gcd_iter_unit.sv
// Self-checking bench for gcd_iter_unit: directed cases plus random operands vs. a modulo-Euclid model.
module tb_gcd_iter_unit;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          START;
    logic          MODE;
    logic [W-1:0]  X;
    logic [W-1:0]  Y;
    logic [W-1:0]  OUT;
    logic          READY;
    logic          BUSY;
    logic [CW-1:0] CYCLES;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    gcd_iter_unit #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .MODE   (MODE),
        .X      (X),
        .Y      (Y),
        .OUT    (OUT),
        .READY  (READY),
        .BUSY   (BUSY),
        .CYCLES (CYCLES)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned p = a;
        int unsigned q = b;
        int unsigned t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return W'(p);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while (READY !== 1'b1 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_ready"}, READY, 1);
    endtask

    task automatic run_op(input string tag, input logic m, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int unsigned budget,
                          output logic [CW-1:0] cyc);
        @(negedge CLK);
        MODE  = m;
        X     = x;
        Y     = y;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check({tag, "_busy_calc"}, BUSY, 1);
        check({tag, "_notready_calc"}, READY, 0);
        wait_ready(tag, budget);
        check({tag, "_out"}, OUT, ref_gcd(x, y));
        check({tag, "_busy_done"}, BUSY, 0);
        cyc = CYCLES;
    endtask

    initial begin
        logic [CW-1:0] c;
        logic [CW-1:0] c_sub;
        logic [CW-1:0] c_bin;
        logic [W-1:0]  rx;
        logic [W-1:0]  ry;
        logic          rm;

        RESET = 1'b1;
        START = 1'b0;
        MODE  = 1'b0;
        X     = '0;
        Y     = '0;
        repeat (2) @(negedge CLK);
        check("rst_out", OUT, 0);
        check("rst_ready", READY, 0);
        check("rst_busy", BUSY, 0);
        check("rst_cycles", CYCLES, 0);
        RESET = 1'b0;

        run_op("t1_123_456", 1'b0, 16'd123, 16'd456, 2000, c);
        check("t1_val", OUT, 3);

        run_op("t2_456_123", 1'b0, 16'd456, 16'd123, 2000, c_sub);
        run_op("t2_eq", 1'b0, 16'd456, 16'd456, 100, c);
        check("t2_eq_val", OUT, 456);
        check("t2_eq_cycles", c, 1);

        run_op("t3_48_180", 1'b1, 16'd48, 16'd180, 200, c);
        check("t3_48_180_val", OUT, 12);
        run_op("t3_bin_456_123", 1'b1, 16'd456, 16'd123, 200, c_bin);
        check("t3_bin_faster", (c_bin < c_sub), 1);

        run_op("t4_0_35", 1'b0, 16'd0, 16'd35, 100, c);
        check("t4_0_35_cycles", c, 1);
        run_op("t4_35_0", 1'b1, 16'd35, 16'd0, 100, c);
        check("t4_35_0_val", OUT, 35);
        run_op("t4_0_0", 1'b0, 16'd0, 16'd0, 100, c);
        check("t4_0_0_val", OUT, 0);
        check("t4_0_0_cycles", c, 1);
        // 65534 single-step subtractions plus the terminating cycle lands exactly on all-ones.
        run_op("t4_ffff_1", 1'b0, 16'd65535, 16'd1, 70000, c);
        check("t4_ffff_1_cycles", c, 16'hFFFF);
        repeat (3) @(negedge CLK);
        check("t4_hold_ready", READY, 1);
        check("t4_hold_out", OUT, 1);

        @(negedge CLK);
        MODE  = 1'b0;
        X     = 16'd123;
        Y     = 16'd456;
        START = 1'b1;
        @(negedge CLK);
        X     = 16'd7;
        Y     = 16'd5;
        MODE  = 1'b1;
        repeat (3) @(negedge CLK);
        START = 1'b0;
        check("t5_busy_held", BUSY, 1);
        wait_ready("t5_ignore", 2000);
        check("t5_ignore_out", OUT, 3);
        run_op("t5_b2b", 1'b1, 16'd48, 16'd180, 200, c);
        check("t5_b2b_val", OUT, 12);

        @(negedge CLK);
        MODE  = 1'b0;
        X     = 16'd123;
        Y     = 16'd456;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("t6_out", OUT, 0);
        check("t6_ready", READY, 0);
        check("t6_busy", BUSY, 0);
        check("t6_cycles", CYCLES, 0);
        repeat (2) @(negedge CLK);
        check("t6_idle_hold", BUSY, 0);
        run_op("t6_12_18", 1'b0, 16'd12, 16'd18, 200, c);
        check("t6_12_18_val", OUT, 6);

        for (int i = 0; i < 20; i++) begin
            rm = 1'($urandom_range(0, 1));
            if (rm) begin
                rx = W'($urandom);
                ry = W'($urandom);
            end else begin
                rx = W'($urandom_range(0, 1023));
                ry = W'($urandom_range(0, 1023));
            end
            run_op($sformatf("rnd%0d_m%0d_%0d_%0d", i, rm, rx, ry), rm, rx, ry, 2000, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
